// File: rtl/fb_access_sched.sv
// Frame-buffer slot scheduler: reserves every 8th cycle for display fetch and drains a
// host write FIFO in the remaining cycles. Optional macro FB_WR_BLANK_ONLY_EN restricts writes to vertical blank.
module fb_access_sched #(
    parameter int H_TOTAL    = 800,
    parameter int V_TOTAL    = 525,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 16
) (
    input  logic                          CLK_25,
    input  logic                          Reset,
    input  logic [9:0]                    pixel_x,
    input  logic [9:0]                    pixel_y,
    input  logic                          inDisplayArea,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [7:0]                    wr_data,
    output logic [ADDR_W-1:0]             ram_addr,
    output logic [7:0]                    ram_wdata,
    output logic                          ram_wren,
    input  logic [7:0]                    ram_q,
    output logic                          pixel_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          drop_err
);
    localparam int PW       = $clog2(FIFO_DEPTH);
    localparam int CW       = PW + 1;
    localparam int GROUPS   = H_ACTIVE / 8;
    localparam int FB_BYTES = GROUPS * V_ACTIVE;

    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
    logic [7:0]        r_fifo_data [FIFO_DEPTH];
    logic              r_fetch_d;
    logic [7:0]        r_byte;
    logic              r_pixel;
    logic              r_drop_err;

    logic              w_fetch_slot;
    logic [9:0]        w_tgt_line;
    logic [7:0]        w_tgt_group;
    logic              w_fetch;
    logic [ADDR_W-1:0] w_fetch_addr;
    logic              w_wr_window;
    logic              w_pop;
    logic              w_push;
    logic [ADDR_W-1:0] w_head_addr;
    logic [7:0]        w_head_data;
    logic              w_head_drop;
    logic              w_wr_issue;

    // Slot x%8==6 prefetches the byte for the next 8-pixel group; x=H_TOTAL-2 primes the next line.
    assign w_fetch_slot = (pixel_x[2:0] == 3'd6);

    always_comb begin
        w_tgt_line  = pixel_y;
        w_tgt_group = {1'b0, pixel_x[9:3]} + 8'd1;
        if (pixel_x == 10'(H_TOTAL - 2)) begin
            w_tgt_line  = (pixel_y == 10'(V_TOTAL - 1)) ? 10'd0 : pixel_y + 10'd1;
            w_tgt_group = 8'd0;
        end
    end

    assign w_fetch      = w_fetch_slot && (w_tgt_group < 8'(GROUPS)) && (w_tgt_line < 10'(V_ACTIVE));
    assign w_fetch_addr = ADDR_W'(w_tgt_line) * ADDR_W'(GROUPS) + ADDR_W'(w_tgt_group);

`ifdef FB_WR_BLANK_ONLY_EN
    assign w_wr_window = (pixel_y >= 10'(V_ACTIVE));
`else
    assign w_wr_window = 1'b1;
`endif

    assign w_head_addr = r_fifo_addr[r_rd_ptr];
    assign w_head_data = r_fifo_data[r_rd_ptr];
    assign w_head_drop = (w_head_addr >= ADDR_W'(FB_BYTES));
    assign w_pop       = !Reset && w_wr_window && !w_fetch && (r_count != '0);
    assign w_wr_issue  = w_pop && !w_head_drop;

    // Ready comes from the registered count only, so a pop never re-opens it in the same cycle.
    assign wr_ready = !Reset && (r_count < CW'(FIFO_DEPTH));
    assign w_push   = wr_valid && wr_ready;

    always_comb begin
        ram_addr  = '0;
        ram_wdata = 8'd0;
        ram_wren  = 1'b0;
        if (w_fetch) begin
            ram_addr = w_fetch_addr;
        end else if (w_wr_issue) begin
            ram_addr  = w_head_addr;
            ram_wdata = w_head_data;
            ram_wren  = 1'b1;
        end
    end

    always_ff @(posedge CLK_25) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= wr_addr;
            r_fifo_data[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge CLK_25) begin
        if (Reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_fetch_d  <= 1'b0;
            r_byte     <= 8'd0;
            r_pixel    <= 1'b0;
            r_drop_err <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count   <= r_count + CW'(w_push) - CW'(w_pop);
            r_fetch_d <= w_fetch;
            if (pixel_x[2:0] == 3'd7)
                r_byte <= r_fetch_d ? ram_q : 8'd0;
            r_pixel <= inDisplayArea & r_byte[3'd7 - pixel_x[2:0]];
            if (w_pop && w_head_drop)
                r_drop_err <= 1'b1;
        end
    end

    assign pixel_out  = r_pixel;
    assign fifo_level = r_count;
    assign drop_err   = r_drop_err;

endmodule

// File: tb/tb_fb_access_sched.sv
// Directed bench for fb_access_sched: drives raster position directly and checks slot decisions,
// FIFO behaviour, drop handling, reset flush and pixel unpacking against hand-computed values.
module tb_fb_access_sched;
    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  px;
    logic [9:0]  py;
    logic        disp;
    logic        wv;
    logic        wr_ready;
    logic [15:0] wa;
    logic [7:0]  wd;
    logic [15:0] ra;
    logic [7:0]  rwd;
    logic        rwe;
    logic [7:0]  rq;
    logic        pix;
    logic [2:0]  lvl;
    logic        derr;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [0:38399];
    logic [7:0] exp_pix;

    always #20 clk = ~clk;

    // Registered single-port RAM, read-before-write.
    always @(posedge clk) begin
        if (ra < 16'd38400) begin
            if (rwe) mem[ra] <= rwd;
            rq <= mem[ra];
        end
    end

    fb_access_sched dut (
        .CLK_25        (clk),
        .Reset         (rst),
        .pixel_x       (px),
        .pixel_y       (py),
        .inDisplayArea (disp),
        .wr_valid      (wv),
        .wr_ready      (wr_ready),
        .wr_addr       (wa),
        .wr_data       (wd),
        .ram_addr      (ra),
        .ram_wdata     (rwd),
        .ram_wren      (rwe),
        .ram_q         (rq),
        .pixel_out     (pix),
        .fifo_level    (lvl),
        .drop_err      (derr)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic pos(input int x, input int y);
        px   = 10'(x);
        py   = 10'(y);
        disp = (x < 640) && (y < 480);
    endtask

    task automatic push(input int a, input int d);
        wv = 1'b1;
        wa = 16'(a);
        wd = 8'(d);
    endtask

    task automatic nopush();
        wv = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        nopush();
        wa = '0;
        wd = '0;
        pos(0, 0);

        // Reset state
        step();
        settle();
        check_eq("rst_wr_ready", 32'(wr_ready), 0);
        check_eq("rst_wren", 32'(rwe), 0);
        check_eq("rst_level", 32'(lvl), 0);
        check_eq("rst_pixel", 32'(pix), 0);
        check_eq("rst_drop", 32'(derr), 0);
        step();
        rst = 1'b0;
        settle();
        check_eq("post_rst_ready", 32'(wr_ready), 1);

        // Preload RAM through the FIFO during blanking
        pos(700, 524); push(0, 8'hCC); settle();
        check_eq("pre_nobypass_wren", 32'(rwe), 0);
        step();
        pos(701, 524); push(500, 8'hFF); settle();
        check_eq("pre0_wren", 32'(rwe), 1);
        check_eq("pre0_addr", 32'(ra), 0);
        check_eq("pre0_wdata", 32'(rwd), 32'hCC);
        step();
        pos(702, 524); nopush(); settle();
        check_eq("pre1_addr", 32'(ra), 500);
        check_eq("pre1_wren", 32'(rwe), 1);
        step();
        pos(703, 524); settle();
        check_eq("pre_level0", 32'(lvl), 0);

        // Line-0 prefetch at x=798 of the last line, then pixel unpacking
        pos(798, 524); settle();
        check_eq("f798_addr", 32'(ra), 0);
        check_eq("f798_wren", 32'(rwe), 0);
        step();
        pos(799, 524); step();
        exp_pix = 8'b1100_1100;
        for (int i = 0; i < 8; i++) begin
            pos(i, 0); settle();
            if (i == 6) check_eq("f_l0_g1_addr", 32'(ra), 1);
            step();
            check_eq($sformatf("pix_x%0d", i), 32'(pix), 32'(exp_pix[7-i]));
        end

`ifndef FB_WR_BLANK_ONLY_EN
        // Fill FIFO while fetch slots block pops, then drain in order
        pos(5, 10); push(100, 8'hA5); settle();
        check_eq("l10_ready", 32'(wr_ready), 1);
        check_eq("l10_nobypass", 32'(rwe), 0);
        step();
        pos(6, 10); push(101, 8'hA6); settle();
        check_eq("l10_fetch_addr", 32'(ra), 801);
        check_eq("l10_fetch_wren", 32'(rwe), 0);
        step();
        push(102, 8'hA7); step();
        push(103, 8'hA8); step();
        pos(7, 10); push(104, 8'hEE); settle();
        check_eq("full_level", 32'(lvl), 4);
        check_eq("full_ready", 32'(wr_ready), 0);
        check_eq("w7_wren", 32'(rwe), 1);
        check_eq("w7_addr", 32'(ra), 100);
        check_eq("w7_data", 32'(rwd), 32'hA5);
        step();
        nopush();
        for (int i = 1; i < 4; i++) begin
            pos(7 + i, 10); settle();
            check_eq($sformatf("w%0d_level", 7 + i), 32'(lvl), 32'(4 - i));
            check_eq($sformatf("w%0d_addr", 7 + i), 32'(ra), 32'(100 + i));
            check_eq($sformatf("w%0d_data", 7 + i), 32'(rwd), 32'(8'hA5 + i));
            step();
        end
        pos(11, 10); settle();
        check_eq("drain_level", 32'(lvl), 0);
        check_eq("drain_wren", 32'(rwe), 0);
        check_eq("drain_addr", 32'(ra), 0);

        // Line 479 x=798: no fetch, slot goes to the pending write, byte_reg clears
        pos(797, 479); push(500, 8'hFF); step();
        pos(798, 479); nopush(); settle();
        check_eq("l479_wren", 32'(rwe), 1);
        check_eq("l479_addr", 32'(ra), 500);
        step();
        pos(799, 479); step();
        pos(0, 480); disp = 1'b1; step();
        check_eq("l479_byte_zero", 32'(pix), 0);
`endif

        // Out-of-range address is dropped and the error sticks
        pos(10, 500); push(38400, 8'h55); settle();
        check_eq("drop_push_wren", 32'(rwe), 0);
        step();
        pos(11, 500); nopush(); settle();
        check_eq("drop_wren", 32'(rwe), 0);
        check_eq("drop_addr", 32'(ra), 0);
        check_eq("drop_level1", 32'(lvl), 1);
        step();
        check_eq("drop_err_set", 32'(derr), 1);
        check_eq("drop_level0", 32'(lvl), 0);
        pos(12, 500); step();
        pos(13, 500); step();
        check_eq("drop_err_sticky", 32'(derr), 1);

        // Reset mid-line with three queued entries
        pos(6, 20);
        for (int i = 0; i < 3; i++) begin
            push(200 + i, 8'h10 + i);
            step();
        end
        nopush(); settle();
        check_eq("pre_flush_level", 32'(lvl), 3);
        pos(7, 20); rst = 1'b1; settle();
        check_eq("in_rst_ready", 32'(wr_ready), 0);
        check_eq("in_rst_wren", 32'(rwe), 0);
        step();
        rst = 1'b0; settle();
        check_eq("flush_level", 32'(lvl), 0);
        check_eq("flush_pixel", 32'(pix), 0);
        check_eq("flush_drop", 32'(derr), 0);
        for (int i = 8; i < 11; i++) begin
            pos(i, 20); settle();
            check_eq($sformatf("flush_x%0d_wren", i), 32'(rwe), 0);
            step();
        end

`ifdef FB_WR_BLANK_ONLY_EN
        // Writes held until vertical blank
        pos(1, 100); push(300, 8'h77); step();
        nopush();
        for (int i = 2; i < 6; i++) begin
            pos(i, 100); settle();
            check_eq($sformatf("blank_hold_x%0d", i), 32'(rwe), 0);
            step();
        end
        pos(799, 479); settle();
        check_eq("blank_hold_479", 32'(rwe), 0);
        check_eq("blank_hold_level", 32'(lvl), 1);
        step();
        pos(0, 480); settle();
        check_eq("blank_wren", 32'(rwe), 1);
        check_eq("blank_addr", 32'(ra), 300);
        check_eq("blank_data", 32'(rwd), 32'h77);
        step();
        check_eq("blank_level0", 32'(lvl), 0);
`else
        // Writes issue in the next non-fetch cycle of an active line
        pos(1, 100); push(300, 8'h77); step();
        pos(2, 100); nopush(); settle();
        check_eq("any_wren", 32'(rwe), 1);
        check_eq("any_addr", 32'(ra), 300);
        check_eq("any_data", 32'(rwd), 32'h77);
        step();
        check_eq("any_level0", 32'(lvl), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fb_access_sched.md
Name: fb_access_sched

Overview:
- Time-slot scheduler for the single-port 1-bpp frame-buffer RAM (640x480, 38400 bytes, byte = 8 horizontal pixels, bit 7 = leftmost pixel).
- Grants the display fetch path a reserved slot every 8 pixels. Buffers host byte writes in a small FIFO and issues them in all other cycles.
- Unpacks each fetched byte into a serial pixel stream that feeds the RGB output registers in top.
- Sits between sync_gen, the host write source and the frame-buffer RAM.

Parameters:
- H_TOTAL, 800, pixels per line including blanking.
- V_TOTAL, 525, lines per frame including blanking.
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines.
- FIFO_DEPTH, 4, host write FIFO entries (power of 2).
- ADDR_W, 16, RAM byte-address width.

Ports:
- CLK_25  in  1  pixel clock.
- Reset  in  1  synchronous, active-high reset.
- pixel_x  in  10  sync_gen CounterX.
- pixel_y  in  10  sync_gen CounterY.
- inDisplayArea  in  1  sync_gen visible flag.
- wr_valid  in  1  host write request.
- wr_ready  out  1  FIFO can accept.
- wr_addr  in  ADDR_W  byte address (line*80 + x/8).
- wr_data  in  8  byte to write.
- ram_addr  out  ADDR_W  RAM address (combinational from slot decision).
- ram_wdata  out  8  RAM write data.
- ram_wren  out  1  RAM write strobe.
- ram_q  in  8  RAM read data, valid 1 cycle after address (registered RAM).
- pixel_out  out  1  current pixel, registered.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries held.
- drop_err  out  1  sticky: a write with address >= 38400 was discarded.

Behaviour:
- Reset (sync, active-high): FIFO flushed, fifo_level=0, wr_ready=0 during reset then 1, ram_wren=0, byte_reg=0, pixel_out=0, drop_err=0.
- Fetch slot: the cycle where pixel_x[2:0]==6.
  - If pixel_x==H_TOTAL-2: target = line (pixel_y+1, wraps V_TOTAL-1 -> 0), group 0.
  - Otherwise: target = line pixel_y, group pixel_x[9:3]+1.
  - Fetch occurs only if target group < 80 and target line < V_ACTIVE. Then ram_addr = line*80 + group and ram_wren=0.
- Load: at the end of every cycle with pixel_x[2:0]==7, byte_reg <= ram_q if a fetch was issued in the previous cycle, else 0.
- pixel_out <= inDisplayArea & byte_reg[7 - pixel_x[2:0]]. Latency 1 cycle from pixel_x, matching the h_sync/v_sync register stage.
- Write slot: any cycle that is not an active fetch.
  - If the FIFO is non-empty: pop head, ram_addr=head addr, ram_wdata=head data, ram_wren=1.
  - If the address >= 38400: pop, ram_wren=0, set drop_err.
  - At most one write per cycle.
- FIFO push: when wr_valid & wr_ready. wr_ready = (fifo_level < FIFO_DEPTH), computed from registered count.
  - Push and pop in the same cycle is legal, including when full (pop frees the slot but ready stays low that cycle) and when empty (no bypass; a new entry is written no earlier than the next cycle).
- Ordering: writes reach RAM in FIFO order. A write to a byte fetched in the same 8-pixel window becomes visible in the next frame.
- Worst-case write throughput: 7 of every 8 cycles in active lines, every cycle in blanking.
- Idle RAM: ram_addr holds 0 and ram_wren=0 when neither a fetch nor a write occurs.

Optional Feature:
- Macro FB_WR_BLANK_ONLY_EN.
- Defined: writes are popped only while pixel_y >= V_ACTIVE (vertical blank), giving tear-free updates. The FIFO fills during the active frame and wr_ready deasserts when full. Fetch behaviour is unchanged.
- Undefined: writes are issued in any non-fetch cycle, as described above.

Test Plan:
- Preload RAM byte 0 = 0xCC, run line 0 from pixel_x 798 of line 524 -> fetch addr 0 at x=798 (prior line). pixel_out at cycles after x=0..7 = 1,1,0,0,1,1,0,0.
- Push 4 writes at pixel_x=5 on line 10 (addrs 100..103, data 0xA5..) -> wr_ready low after 4th push. Cycle x=6 shows a fetch (addr 10*80+1=801, wren=0). Writes appear in cycles x=7,8,9,10 in order; fifo_level returns to 0.
- Write addr 38400 -> ram_wren never asserted, entry popped, drop_err=1 and stays 1 until Reset.
- Line 479, x=798 -> no fetch (target line 480). Slot used by a pending write; byte_reg loads 0 at x=799.
- Assert Reset for 1 cycle with 3 FIFO entries mid-line -> fifo_level=0, pixel_out=0, no further ram_wren from the flushed entries.
- With FB_WR_BLANK_ONLY_EN defined, push at line 100 -> no ram_wren until pixel_y=480, x=0. The write is issued in that cycle.
